tile_shuffler: RTL and testbench

Generates a fresh random tile layout for each game round: a permutation of the 24 edge-track picture tiles and a permutation of the 12 centre face-down tiles. It uses a free-running 16-bit LFSR and an in-place Fisher-Yates shuffle. It sits directly upstream of the order-selection/board logic and replaces its fixed order tables with a true per-round permutation, packed in the same 6-bit-per-slot format. Outputs change atomically, once per completed shuffle.

---
 rtl/tile_shuffler.sv | 140 ++++++++++++++
 tb/tb_tile_shuffler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_shuffler.sv
`timescale 1ns/1ps
// tile_shuffler: per-round random layout generator. A free-running 16-bit
// Galois LFSR drives an in-place Fisher-Yates shuffle of the edge-track and
// centre tile arrays; the shuffled orders are published atomically on FINISH.
module tile_shuffler #(
    parameter int EDGE_N   = 24,
    parameter int CENTER_N = 12,
    parameter int ID_W     = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       seed_load,
    input  logic [15:0]                seed,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [EDGE_N*ID_W-1:0]     edge_order,
    output logic [CENTER_N*ID_W-1:0]   center_order
);

    // I_W holds i+1 up to EDGE_N; EI_W/CI_W address the two working arrays.
    localparam int I_W  = $clog2(EDGE_N + 1);
    localparam int EI_W = $clog2(EDGE_N);
    localparam int CI_W = $clog2(CENTER_N);
    localparam logic [15:0] LFSR_RST  = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_EDGE, S_CENTER, S_FINISH} state_e;

    state_e                    state_q, state_d;
    logic [15:0]               lfsr_q, lfsr_d;
    logic [I_W-1:0]            i_q, i_d;
    logic [I_W-1:0]            ip1;
    logic [8+I_W-1:0]          prod;
    logic [I_W-1:0]            j;
    logic [ID_W-1:0]           wedge_q [EDGE_N];
    logic [ID_W-1:0]           wcen_q  [CENTER_N];
    logic                      done_q;
    logic [EDGE_N*ID_W-1:0]    edge_order_q;
    logic [CENTER_N*ID_W-1:0]  center_order_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: start only honoured in IDLE, loops end when i reaches 1
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_INIT;
            S_INIT:   state_d = S_EDGE;
            S_EDGE:   if (i_q == I_W'(1)) state_d = S_CENTER;
            S_CENTER: if (i_q == I_W'(1)) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; busy covers INIT through FINISH
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // LFSR next value: seed load wins over stepping; zero seed would lock up
    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        if (seed_load) lfsr_d = (seed == 16'h0000) ? LFSR_RST : seed;
    end

    // Swap index j = (lfsr[15:8] * (i+1)) >> 8 lands in 0..i; loop counter update
    always_comb begin
        ip1  = i_q + I_W'(1);
        prod = {{I_W{1'b0}}, lfsr_q[15:8]} * {8'b0, ip1};
        j    = I_W'(prod >> 8);
        i_d  = i_q;
        case (state_q)
            S_INIT:   i_d = I_W'(EDGE_N - 1);
            S_EDGE:   i_d = (i_q == I_W'(1)) ? I_W'(CENTER_N - 1) : i_q - I_W'(1);
            S_CENTER: i_d = i_q - I_W'(1);
            default:  i_d = i_q;
        endcase
    end

    // LFSR and loop counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_RST;
            i_q    <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            i_q    <= i_d;
        end
    end

    // Working arrays: identity on reset/INIT, one Fisher-Yates swap per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < EDGE_N; k++)   wedge_q[k] <= ID_W'(k);
            for (int k = 0; k < CENTER_N; k++) wcen_q[k]  <= ID_W'(k);
        end else begin
            case (state_q)
                S_INIT: begin
                    for (int k = 0; k < EDGE_N; k++)   wedge_q[k] <= ID_W'(k);
                    for (int k = 0; k < CENTER_N; k++) wcen_q[k]  <= ID_W'(k);
                end
                S_EDGE: begin
                    wedge_q[i_q[EI_W-1:0]] <= wedge_q[j[EI_W-1:0]];
                    wedge_q[j[EI_W-1:0]]   <= wedge_q[i_q[EI_W-1:0]];
                end
                S_CENTER: begin
                    wcen_q[i_q[CI_W-1:0]] <= wcen_q[j[CI_W-1:0]];
                    wcen_q[j[CI_W-1:0]]   <= wcen_q[i_q[CI_W-1:0]];
                end
                default: ;
            endcase
        end
    end

    // Published orders: updated only on the FINISH edge so no partial shuffle is visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            for (int k = 0; k < EDGE_N; k++)   edge_order_q[k*ID_W +: ID_W]   <= ID_W'(k);
            for (int k = 0; k < CENTER_N; k++) center_order_q[k*ID_W +: ID_W] <= ID_W'(k);
        end else begin
            done_q <= (state_q == S_FINISH);
            if (state_q == S_FINISH) begin
                for (int k = 0; k < EDGE_N; k++)   edge_order_q[k*ID_W +: ID_W]   <= wedge_q[k];
                for (int k = 0; k < CENTER_N; k++) center_order_q[k*ID_W +: ID_W] <= wcen_q[k];
            end
        end
    end

    assign done         = done_q;
    assign edge_order   = edge_order_q;
    assign center_order = center_order_q;

endmodule

// File: tb/tb_tile_shuffler.sv
`timescale 1ns/1ps
// Bench for tile_shuffler: reset values, seeded shuffles checked against a
// behavioural LFSR + Fisher-Yates model, timing, ignored starts, mid-run reset.
module tb_tile_shuffler;

    localparam int EN = 24;
    localparam int CN = 12;
    localparam int IW = 6;
    localparam int NV = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              seed_load = 1'b0;
    logic [15:0]       seed = 16'h0000;
    logic              start = 1'b0;
    logic              busy, done;
    logic [EN*IW-1:0]  edge_order;
    logic [CN*IW-1:0]  center_order;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] seed;
        int          gap;
        bit          pulse;
    } vec_t;

    vec_t           vecs [NV];
    logic [143:0]   res_e [NV];
    logic [71:0]    res_c [NV];
    logic [143:0]   ident_e;
    logic [71:0]    ident_c;

    always #5 clk = ~clk;

    tile_shuffler #(.EDGE_N(EN), .CENTER_N(CN), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .start(start), .busy(busy), .done(done),
        .edge_order(edge_order), .center_order(center_order)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic bit perm_ok(input logic [143:0] v, input int n);
        bit seen [EN];
        int val;
        for (int k = 0; k < EN; k++) seen[k] = 1'b0;
        for (int k = 0; k < n; k++) begin
            val = int'(v[k*IW +: IW]);
            if (val >= n) return 1'b0;
            if (seen[val]) return 1'b0;
            seen[val] = 1'b1;
        end
        return 1'b1;
    endfunction

    // Reference shuffle: first swap uses the LFSR value gap+1 steps after the seed edge.
    task automatic model(input logic [15:0] s, input int gap,
                         output logic [143:0] eo, output logic [71:0] co);
        int we [EN];
        int wc [CN];
        int j, t;
        logic [15:0] l;
        l = s;
        for (int n = 0; n < gap + 1; n++) l = lstep(l);
        for (int k = 0; k < EN; k++) we[k] = k;
        for (int k = 0; k < CN; k++) wc[k] = k;
        for (int i = EN - 1; i >= 1; i--) begin
            j = (int'(l[15:8]) * (i + 1)) >> 8;
            t = we[i]; we[i] = we[j]; we[j] = t;
            l = lstep(l);
        end
        for (int i = CN - 1; i >= 1; i--) begin
            j = (int'(l[15:8]) * (i + 1)) >> 8;
            t = wc[i]; wc[i] = wc[j]; wc[j] = t;
            l = lstep(l);
        end
        eo = '0;
        co = '0;
        for (int k = 0; k < EN; k++) eo[k*IW +: IW] = 6'(we[k]);
        for (int k = 0; k < CN; k++) co[k*IW +: IW] = 6'(wc[k]);
    endtask

    // Seed, start after 'gap' cycles, observe 80 cycles from the start edge.
    task automatic run(input logic [15:0] sd, input int gap, input bit pulse, input string tag,
                       output logic [143:0] eo, output logic [71:0] co);
        logic [143:0] pre_e, me;
        logic [71:0]  pre_c, mc;
        int nbusy, ndone, first_done;
        bit stable;
        nbusy = 0; ndone = 0; first_done = -1; stable = 1'b1;
        pre_e = edge_order;
        pre_c = center_order;
        seed = sd;
        seed_load = 1'b1;
        start = (gap == 0);
        tick;
        seed_load = 1'b0;
        if (gap > 0) begin
            start = 1'b0;
            for (int g = 1; g < gap; g++) tick;
            start = 1'b1;
            tick;
        end
        start = 1'b0;
        for (int k = 0; k <= 80; k++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
            if (k < 36 && (edge_order !== pre_e || center_order !== pre_c)) stable = 1'b0;
            start = pulse && (k + 1 == 5 || k + 1 == 20);
            if (k < 80) tick;
        end
        start = 1'b0;
        model((sd == 16'h0000) ? 16'hACE1 : sd, gap, me, mc);
        chk($sformatf("%s busy_cycles", tag), 144'(nbusy), 144'd36);
        chk($sformatf("%s done_latency", tag), 144'(first_done), 144'd36);
        chk($sformatf("%s done_count", tag), 144'(ndone), 144'd1);
        chk($sformatf("%s outputs_stable", tag), 144'(stable), 144'd1);
        chk($sformatf("%s edge_is_perm", tag), 144'(perm_ok(edge_order, EN)), 144'd1);
        chk($sformatf("%s center_is_perm", tag), 144'(perm_ok(144'(center_order), CN)), 144'd1);
        chk($sformatf("%s edge_vs_model", tag), edge_order, me);
        chk($sformatf("%s center_vs_model", tag), 144'(center_order), 144'(mc));
        eo = edge_order;
        co = center_order;
    endtask

    initial begin
        int nb, nd;
        vecs[0] = '{seed: 16'h1234, gap: 1, pulse: 1'b0};
        vecs[1] = '{seed: 16'h1234, gap: 1, pulse: 1'b0};
        vecs[2] = '{seed: 16'h1235, gap: 1, pulse: 1'b0};
        vecs[3] = '{seed: 16'h0000, gap: 1, pulse: 1'b0};
        vecs[4] = '{seed: 16'hACE1, gap: 1, pulse: 1'b0};
        vecs[5] = '{seed: 16'h0001, gap: 0, pulse: 1'b0};
        vecs[6] = '{seed: 16'hBEEF, gap: 3, pulse: 1'b1};
        ident_e = '0;
        ident_c = '0;
        for (int k = 0; k < EN; k++) ident_e[k*IW +: IW] = 6'(k);
        for (int k = 0; k < CN; k++) ident_c[k*IW +: IW] = 6'(k);

        // Power-on reset
        repeat (3) tick;
        chk("reset busy", 144'(busy), 144'd0);
        chk("reset done", 144'(done), 144'd0);
        chk("reset edge_order", edge_order, ident_e);
        chk("reset center_order", 144'(center_order), 144'(ident_c));
        rst_n = 1'b1;
        repeat (2) tick;

        for (int v = 0; v < NV; v++) begin
            run(vecs[v].seed, vecs[v].gap, vecs[v].pulse, $sformatf("vec%0d", v), res_e[v], res_c[v]);
            repeat (2) tick;
        end

        chk("determinism edge", res_e[1], res_e[0]);
        chk("determinism center", 144'(res_c[1]), 144'(res_c[0]));
        checks++;
        if (res_e[2] === res_e[0]) begin
            failures++;
            $display("FAIL seed_change edge: got %h required different from %h", res_e[2], res_e[0]);
        end
        chk("zero_seed edge", res_e[3], res_e[4]);
        chk("zero_seed center", 144'(res_c[3]), 144'(res_c[4]));

        // Reset in the middle of a shuffle
        seed = 16'h1234;
        seed_load = 1'b1;
        tick;
        seed_load = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (15) tick;
        rst_n = 1'b0;
        #2;
        chk("midreset busy", 144'(busy), 144'd0);
        chk("midreset done", 144'(done), 144'd0);
        chk("midreset edge_order", edge_order, ident_e);
        chk("midreset center_order", 144'(center_order), 144'(ident_c));
        repeat (2) tick;
        rst_n = 1'b1;
        nb = 0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            tick;
            if (busy) nb++;
            if (done) nd++;
        end
        chk("midreset no_done", 144'(nd), 144'd0);
        chk("midreset no_busy", 144'(nb), 144'd0);
        run(16'h5A5A, 2, 1'b0, "post_reset", res_e[0], res_c[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
